// File: rtl/hsv_pkg.sv
// Shared types and constants for the HSV threshold calibrator: FSM encoding,
// packed bound field offsets and saturating margin helpers.
package hsv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_COMMIT = 2'd3
  } cal_state_t;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned HSV_W    = 3 * PIX_W;
  localparam int unsigned BOUNDS_W = 6 * PIX_W;
  localparam int unsigned CNT_W    = 12;

  // Bit offsets of each 8-bit field inside a 48-bit bound set.
  localparam int unsigned H_LO = 40;
  localparam int unsigned H_HI = 32;
  localparam int unsigned S_LO = 24;
  localparam int unsigned S_HI = 16;
  localparam int unsigned V_LO = 8;
  localparam int unsigned V_HI = 0;

  localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;
  localparam logic [PIX_W-1:0] PIX_MIN = 8'h00;

  function automatic logic [PIX_W-1:0] sat_sub(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] m);
    return (a >= m) ? (a - m) : PIX_MIN;
  endfunction

  // Sum is formed one bit wider so the overflow test happens before truncation.
  function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] m);
    logic [PIX_W:0] s;
    s = {1'b0, a} + {1'b0, m};
    return (s > {1'b0, PIX_MAX}) ? PIX_MAX : s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/hsv_minmax.sv
// Per-channel running minimum and maximum of H, S and V.
module hsv_minmax
  import hsv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [HSV_W-1:0] i_pixel,
  output logic [HSV_W-1:0] o_min,
  output logic [HSV_W-1:0] o_max
);

  logic [HSV_W-1:0] r_min;
  logic [HSV_W-1:0] r_max;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_min <= {3{PIX_MAX}};
      r_max <= {3{PIX_MIN}};
    end else if (i_en) begin
      for (int c = 0; c < 3; c++) begin
        if (i_pixel[c*PIX_W +: PIX_W] < r_min[c*PIX_W +: PIX_W])
          r_min[c*PIX_W +: PIX_W] <= i_pixel[c*PIX_W +: PIX_W];
        if (i_pixel[c*PIX_W +: PIX_W] > r_max[c*PIX_W +: PIX_W])
          r_max[c*PIX_W +: PIX_W] <= i_pixel[c*PIX_W +: PIX_W];
      end
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/threshold_calibrator.sv
// Samples a fixed screen window for one frame and rewrites the blue or green
// HSV threshold bounds from the observed min/max, widened by MARGIN.
module threshold_calibrator
  import hsv_pkg::*;
#(
  parameter logic [10:0]         WIN_X0        = 11'd496,
  parameter logic [9:0]          WIN_Y0        = 10'd368,
  parameter logic [5:0]          WIN_SIZE      = 6'd32,
  parameter logic [7:0]          MARGIN        = 8'd8,
  parameter logic [BOUNDS_W-1:0] BLUE_DEFAULT  = 48'h64_82_50_FF_32_FF,
  parameter logic [BOUNDS_W-1:0] GREEN_DEFAULT = 48'h28_50_46_FF_28_FF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic [10:0]         hcount,
  input  logic [9:0]          vcount,
  input  logic [HSV_W-1:0]    hsv_pixel,
  input  logic                pixel_valid,
  input  logic                cal_req,
  input  logic                cal_sel,
  output logic [BOUNDS_W-1:0] blue_bounds,
  output logic [BOUNDS_W-1:0] green_bounds,
  output logic                busy,
  output logic                done,
  output logic                cal_err
);

  cal_state_t          r_state;
  logic                r_sel;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [CNT_W-1:0]    r_count;
  logic [BOUNDS_W-1:0] r_blue;
  logic [BOUNDS_W-1:0] r_green;

  logic                w_in_x;
  logic                w_in_y;
  logic                w_clear;
  logic                w_sample;
  logic [HSV_W-1:0]    w_min;
  logic [HSV_W-1:0]    w_max;
  logic [BOUNDS_W-1:0] w_new_bounds;

  // Window ends are formed one bit wider than the coordinates so they cannot wrap.
  assign w_in_x = (hcount >= WIN_X0) &&
                  (12'(hcount) < (12'(WIN_X0) + 12'(WIN_SIZE)));
  assign w_in_y = (vcount >= WIN_Y0) &&
                  (11'(vcount) < (11'(WIN_Y0) + 11'(WIN_SIZE)));

  assign w_clear  = (r_state == ST_ARM) && frame_start;
  assign w_sample = (r_state == ST_SAMPLE) && !frame_start &&
                    pixel_valid && w_in_x && w_in_y;

  hsv_minmax u_minmax (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_en    (w_sample),
    .i_pixel (hsv_pixel),
    .o_min   (w_min),
    .o_max   (w_max)
  );

  always_comb begin
    w_new_bounds             = '0;
    w_new_bounds[H_LO +: 8]  = sat_sub(w_min[23:16], MARGIN);
    w_new_bounds[H_HI +: 8]  = sat_add(w_max[23:16], MARGIN);
    w_new_bounds[S_LO +: 8]  = sat_sub(w_min[15:8],  MARGIN);
    w_new_bounds[S_HI +: 8]  = sat_add(w_max[15:8],  MARGIN);
    w_new_bounds[V_LO +: 8]  = sat_sub(w_min[7:0],   MARGIN);
    w_new_bounds[V_HI +: 8]  = sat_add(w_max[7:0],   MARGIN);
  end

  // The closing frame_start is where bounds, done and cal_err are loaded, so
  // all three become visible together in the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
      r_blue  <= BLUE_DEFAULT;
      r_green <= GREEN_DEFAULT;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cal_req) begin
            r_sel   <= cal_sel;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (frame_start) begin
            r_count <= '0;
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (frame_start) begin
            r_done  <= 1'b1;
            r_state <= ST_COMMIT;
            if (r_count == '0)
              r_err <= 1'b1;
            else if (r_sel)
              r_green <= w_new_bounds;
            else
              r_blue <= w_new_bounds;
          end else if (w_sample && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign blue_bounds  = r_blue;
  assign green_bounds = r_green;
  assign busy         = r_busy;
  assign done         = r_done;
  assign cal_err      = r_err;

endmodule

// File: tb/tb_threshold_calibrator.sv
// Directed bench for threshold_calibrator with hand-computed bound values.
module tb_threshold_calibrator;

  localparam logic [47:0] BLUE_DEF  = 48'h64_82_50_FF_32_FF;
  localparam logic [47:0] GREEN_DEF = 48'h28_50_46_FF_28_FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [23:0] hsv_pixel;
  logic        pixel_valid;
  logic        cal_req;
  logic        cal_sel;
  logic [47:0] blue_bounds;
  logic [47:0] green_bounds;
  logic        busy;
  logic        done;
  logic        cal_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  threshold_calibrator #(
    .WIN_X0        (11'd496),
    .WIN_Y0        (10'd368),
    .WIN_SIZE      (6'd32),
    .MARGIN        (8'd8),
    .BLUE_DEFAULT  (BLUE_DEF),
    .GREEN_DEFAULT (GREEN_DEF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .hcount       (hcount),
    .vcount       (vcount),
    .hsv_pixel    (hsv_pixel),
    .pixel_valid  (pixel_valid),
    .cal_req      (cal_req),
    .cal_sel      (cal_sel),
    .blue_bounds  (blue_bounds),
    .green_bounds (green_bounds),
    .busy         (busy),
    .done         (done),
    .cal_err      (cal_err)
  );

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [10:0] h, input logic [9:0] v,
                     input logic [23:0] p, input logic vld);
    hcount      = h;
    vcount      = v;
    hsv_pixel   = p;
    pixel_valid = vld;
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic start_cal(input string tag, input logic sel);
    cal_sel = sel;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    check({tag, "_busy_acc"}, 48'(busy), 48'd1);
  endtask

  task automatic arm_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Closing frame_start: done must be low before it and high exactly one cycle later.
  task automatic end_frame(input string tag);
    frame_start = 1'b1;
    check({tag, "_done_pre"}, 48'(done), 48'd0);
    tick();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    check({tag, "_done"}, 48'(done), 48'd1);
    check({tag, "_busy_commit"}, 48'(busy), 48'd1);
    tick();
    check({tag, "_done_low"}, 48'(done), 48'd0);
    check({tag, "_busy_idle"}, 48'(busy), 48'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0; hcount = '0; vcount = '0;
    hsv_pixel = '0; pixel_valid = 1'b0; cal_req = 1'b0; cal_sel = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_blue", blue_bounds, BLUE_DEF);
    check("rst_green", green_bounds, GREEN_DEF);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_done", 48'(done), 48'd0);
    check("rst_err", 48'(cal_err), 48'd0);

    // Uniform window: H=40 S=80 V=C0 into blue.
    start_cal("t1", 1'b0);
    arm_frame();
    pix(11'd496, 10'd368, 24'h40_80_C0, 1'b1);
    pix(11'd527, 10'd399, 24'h40_80_C0, 1'b1);
    pix(11'd510, 10'd380, 24'h40_80_C0, 1'b1);
    pix(11'd496, 10'd399, 24'h40_80_C0, 1'b1);
    end_frame("t1");
    check("t1_blue", blue_bounds, 48'h38_48_78_88_B8_C8);
    check("t1_green", green_bounds, GREEN_DEF);
    check("t1_err", 48'(cal_err), 48'd0);

    // Saturation at both ends of H, into green.
    start_cal("t2", 1'b1);
    arm_frame();
    pix(11'd500, 10'd370, 24'h03_50_60, 1'b1);
    pix(11'd520, 10'd390, 24'hFA_70_90, 1'b1);
    end_frame("t2");
    check("t2_green", green_bounds, 48'h00_FF_48_78_58_98);
    check("t2_blue", blue_bounds, 48'h38_48_78_88_B8_C8);

    // No valid pixels: error, bounds untouched, error sticky.
    start_cal("t3", 1'b0);
    arm_frame();
    pix(11'd500, 10'd370, 24'h00_00_00, 1'b0);
    pix(11'd510, 10'd380, 24'hFF_FF_FF, 1'b0);
    end_frame("t3");
    check("t3_err", 48'(cal_err), 48'd1);
    check("t3_blue", blue_bounds, 48'h38_48_78_88_B8_C8);
    check("t3_green", green_bounds, 48'h00_FF_48_78_58_98);
    tick();
    check("t3_err_sticky", 48'(cal_err), 48'd1);

    // Window edges, ARM-time pixel, in-flight cal_req and a pixel on the closing frame_start.
    start_cal("t4", 1'b0);
    check("t4_err_clr", 48'(cal_err), 48'd0);
    pix(11'd500, 10'd370, 24'h00_00_00, 1'b1);
    arm_frame();
    pix(11'd495, 10'd370, 24'h00_00_00, 1'b1);
    pix(11'd528, 10'd370, 24'hFF_FF_FF, 1'b1);
    pix(11'd500, 10'd367, 24'h00_00_00, 1'b1);
    pix(11'd500, 10'd400, 24'hFF_FF_FF, 1'b1);
    pix(11'd527, 10'd399, 24'h20_30_F7, 1'b1);
    cal_sel = 1'b1; cal_req = 1'b1;
    pix(11'd496, 10'd368, 24'h28_38_F7, 1'b1);
    cal_req = 1'b0;
    hcount = 11'd510; vcount = 10'd380; hsv_pixel = 24'h00_FF_00; pixel_valid = 1'b1;
    end_frame("t4");
    check("t4_blue", blue_bounds, 48'h18_30_28_40_EF_FF);
    check("t4_green", green_bounds, 48'h00_FF_48_78_58_98);
    arm_frame();
    check("t4_no_queue", 48'(busy), 48'd0);

    // Reset during SAMPLE abandons the calibration and restores defaults.
    start_cal("t5", 1'b1);
    arm_frame();
    pix(11'd500, 10'd370, 24'h10_10_10, 1'b1);
    cal_sel = 1'b0; cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    check("t5_busy_pre", 48'(busy), 48'd1);
    reset = 1'b1; frame_start = 1'b1; cal_req = 1'b1;
    tick();
    reset = 1'b0; frame_start = 1'b0; cal_req = 1'b0;
    check("t5_busy", 48'(busy), 48'd0);
    check("t5_done", 48'(done), 48'd0);
    check("t5_blue", blue_bounds, BLUE_DEF);
    check("t5_green", green_bounds, GREEN_DEF);
    for (int i = 0; i < 3; i++) begin
      arm_frame();
      check("t5_no_done", 48'(done), 48'd0);
      check("t5_idle", 48'(busy), 48'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
